// File: rtl/cpu_control_fsm_if.sv
// Control-sequencer bus: datapath inputs to the sequencer and the strobes it issues.
interface cpu_control_fsm_if;
  logic        run;
  logic        step;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic        write_ir;
  logic        write_pc;
  logic        pc_load;
  logic [3:0]  alu_op;
  logic        alu_b_imm;
  logic        flag_we;
  logic        mem_re;
  logic        mem_we;
  logic        rf_we;
  logic        rf_src_mem;
  logic        illegal;
  logic        halted;

  modport master (
    input  run, step, IR, W_IR_valid,
    output write_ir, write_pc, pc_load, alu_op, alu_b_imm, flag_we,
           mem_re, mem_we, rf_we, rf_src_mem, illegal, halted
  );

  modport slave (
    output run, step, IR, W_IR_valid,
    input  write_ir, write_pc, pc_load, alu_op, alu_b_imm, flag_we,
           mem_re, mem_we, rf_we, rf_src_mem, illegal, halted
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer with retired-instruction counter.
// Optional single-step mode: define CPU_CTRL_STEP_EN.
module cpu_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cpu_control_fsm_if.master  bus,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire_c;
  logic             start_c;
  state_t           wb_nxt_c;

  logic write_ir_c, write_pc_c, pc_load_c, flag_we_c;
  logic mem_re_c, mem_we_c, rf_we_c, rf_src_mem_c, illegal_c, halted_c;

  // Instruction class decode from the latched IR
  logic is_dp, is_ls, is_b, is_swi, is_undef, is_load, is_cmp;
  assign is_dp    = (bus.IR[27:26] == 2'b00);
  assign is_ls    = (bus.IR[27:26] == 2'b01);
  assign is_b     = (bus.IR[27:26] == 2'b10);
  assign is_swi   = (bus.IR[27:24] == 4'b1111);
  assign is_undef = (bus.IR[27:26] == 2'b11) && !is_swi;
  assign is_load  = bus.IR[20];
  assign is_cmp   = (bus.IR[24:23] == 2'b10);

`ifdef CPU_CTRL_STEP_EN
  localparam state_t RETIRE_NXT = S_IDLE;
  assign start_c  = bus.step;
  assign wb_nxt_c = S_IDLE;
`else
  localparam state_t RETIRE_NXT = S_FETCH;
  assign start_c  = bus.run;
  assign wb_nxt_c = bus.run ? S_FETCH : S_IDLE;
  logic unused_step;
  assign unused_step = bus.step;
`endif

  logic unused_ir;
  assign unused_ir = ^{bus.IR[31:28], bus.IR[19:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state and Moore strobes from state and IR
  always_comb begin
    state_d      = state_q;
    retire_c     = 1'b0;
    write_ir_c   = 1'b0;
    write_pc_c   = 1'b0;
    pc_load_c    = 1'b0;
    flag_we_c    = 1'b0;
    mem_re_c     = 1'b0;
    mem_we_c     = 1'b0;
    rf_we_c      = 1'b0;
    rf_src_mem_c = 1'b0;
    illegal_c    = 1'b0;
    halted_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_c) state_d = S_FETCH;
      end
      S_FETCH: begin
        write_ir_c = 1'b1;
        write_pc_c = 1'b1;
        if (bus.W_IR_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_undef) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else if (is_swi) begin
          retire_c = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_dp) begin
          flag_we_c = bus.IR[20];
          if (is_cmp) begin
            retire_c = 1'b1;
            state_d  = RETIRE_NXT;
          end else begin
            state_d = S_WB;
          end
        end else if (is_ls) begin
          state_d = S_MEM;
        end else if (is_b) begin
          pc_load_c = 1'b1;
          retire_c  = 1'b1;
          state_d   = RETIRE_NXT;
        end else begin
          // IR changed under us to a non-executable class: refetch
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_load) begin
          mem_re_c = 1'b1;
          state_d  = S_WB;
        end else begin
          mem_we_c = 1'b1;
          retire_c = 1'b1;
          state_d  = RETIRE_NXT;
        end
      end
      S_WB: begin
        rf_we_c      = 1'b1;
        rf_src_mem_c = is_load;
        retire_c     = 1'b1;
        state_d      = wb_nxt_c;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.write_ir   = write_ir_c;
  assign bus.write_pc   = write_pc_c;
  assign bus.pc_load    = pc_load_c;
  assign bus.alu_op     = bus.IR[24:21];
  assign bus.alu_b_imm  = bus.IR[25];
  assign bus.flag_we    = flag_we_c;
  assign bus.mem_re     = mem_re_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.rf_we      = rf_we_c;
  assign bus.rf_src_mem = rf_src_mem_c;
  assign bus.illegal    = illegal_c;
  assign bus.halted     = halted_c;

  assign state     = 3'(state_q);
  assign instr_cnt = cnt_q;

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the processor core. It drives the `write_ir`/`write_pc` strobes of `fetch_instruction`, decodes the latched `IR`, and steps each instruction through decode, execute, memory and write-back, issuing register-file, ALU-flag, memory and PC-load strobes. The state register updates on `posedge clk`; the datapath samples the strobes on `negedge clk`, so every strobe is stable for half a cycle before use.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` input 1: system clock; state and counter update on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `run` input 1: enable. Sampled in IDLE and at the end of WB.
- `step` input 1: single-step request pulse. Used only with `CPU_CTRL_STEP_EN`.
- `IR` input 32: latched instruction from `fetch_instruction`.
- `W_IR_valid` input 1: condition-pass flag of the instruction being fetched.
- `write_ir` output 1: IR load strobe.
- `write_pc` output 1: PC+4 strobe.
- `pc_load` output 1: load PC with the branch target.
- `alu_op` output 4: equals `IR[24:21]`.
- `alu_b_imm` output 1: equals `IR[25]`.
- `flag_we` output 1: NZCV update strobe.
- `mem_re` output 1: data-memory read strobe.
- `mem_we` output 1: data-memory write strobe.
- `rf_we` output 1: register-file write strobe.
- `rf_src_mem` output 1: write-back source is memory (1) or ALU (0).
- `illegal` output 1: undefined-instruction indication.
- `halted` output 1: core halted.
- `state` output 3: current state, for debug.
- `instr_cnt` output CNT_W: count of retired instructions.

## Operation
- Instruction class from `IR[27:26]`:
  - 00 is DP (data processing).
  - 01 is LS (load/store); `IR[20]`=1 is a load.
  - 10 is B (branch); the link bit is ignored.
  - 11 with `IR[27:24]`=1111 is SWI; any other 11 encoding is undefined.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and goes to IDLE.
- IDLE: goes to FETCH when `run`=1.
- FETCH:
  - Asserts `write_ir` and `write_pc`.
  - Goes to DECODE if `W_IR_valid`=1.
  - Otherwise stays in FETCH. The failed-condition instruction is skipped: PC advances, IR holds, counter is unchanged.
- DECODE:
  - DP, LS and B go to EXEC.
  - SWI goes to HALT.
  - Undefined asserts `illegal` and goes to FETCH.
- EXEC:
  - DP: `flag_we`=`IR[20]`. Opcodes 10xx (TST/TEQ/CMP/CMN) retire and go to FETCH; all other opcodes go to WB.
  - LS: goes to MEM.
  - B: asserts `pc_load`, retires, goes to FETCH.
- MEM:
  - Load: asserts `mem_re`, goes to WB.
  - Store: asserts `mem_we`, retires, goes to FETCH.
- WB:
  - Asserts `rf_we`; `rf_src_mem`=1 for a load.
  - Retires.
  - Goes to FETCH if `run`=1, else IDLE.
- HALT: `halted`=1. Leaves only on reset. SWI counts as retired.
- Retire: `instr_cnt` increments by 1 on the transition out of the retiring state. It wraps from all-ones to 0.
- All strobes are Moore-decoded from `state` and `IR`. Each is high for exactly one cycle per visit to its state.

## Timing
- Reset: after a rising edge with `rst`=0, the outputs are:
  - `state`=IDLE.
  - `instr_cnt`=0.
  - All strobes, `illegal` and `halted` are 0.
  - `alu_op` and `alu_b_imm` follow `IR`.
- Reset mid-instruction aborts immediately: no further strobes after that edge.
- `rst` has priority over every other input.
- Cycles from FETCH entry to the next FETCH:
  - DP with write-back: 4.
  - Compare: 3.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Skipped condition: 1.
  - Undefined: 2.
- `run` dropping mid-instruction does not stall the sequence; it is acted on only in WB and IDLE. Instructions that retire straight to FETCH continue fetching.
- `W_IR_valid` is sampled only in FETCH.

## Configuration
- `CPU_CTRL_STEP_EN` defined:
  - Every retiring transition goes to IDLE instead of FETCH, including WB regardless of `run`.
  - IDLE goes to FETCH only on `step`=1; `run` is ignored in IDLE.
  - Exactly one instruction retires per `step` pulse.
- Not defined: `step` is ignored and the sequencing above applies.

## Test plan
- Reset/run: `rst`=0 for 2 cycles, then `rst`=1 and `run`=1 with `IR`=0xE0810002 (ADD) → states 0,1,2,3,5,1. `rf_we` high for exactly one cycle; `instr_cnt`=1.
- Compare and condition: `IR`=0xE1500001 (CMP, S=1) → `flag_we` in EXEC, no `rf_we`, 3 cycles. Then hold `W_IR_valid`=0 for 3 FETCH cycles → 3 `write_pc` pulses, no DECODE, `instr_cnt` unchanged.
- Memory:
  - `IR`=0xE5910000 (LDR) → `mem_re` in MEM, `rf_we` with `rf_src_mem`=1, 5 cycles.
  - `IR`=0xE5810000 (STR) → `mem_we`, no `rf_we`, 4 cycles.
- Control flow:
  - `IR`=0xEA000003 (B) → `pc_load` in EXEC, 3 cycles.
  - `IR`=0xEF000000 (SWI) → HALT, `halted`=1 held until reset.
  - `IR`=0xEC000000 (undefined) → `illegal` pulse in DECODE, back to FETCH.
- Boundaries:
  - Pulse `rst`=0 during MEM of a load → IDLE next edge, no `rf_we`.
  - Preload `instr_cnt`=0xFFFF by 65535 compares → next retire gives 0.
- Step mode (`CPU_CTRL_STEP_EN`): `run`=1 and 3 `step` pulses → exactly 3 retirements, IDLE between each.
